id_exe_pipe_reg: RTL and testbench
==================================

// Module: id_exe_pipe_reg
// PURPOSE
// ID->EXE pipeline register, directly downstream of data_forward. Each cycle selects rs/rt/hi/lo
// operands (forwarded value vs register-file value), latches them with decoded control into EXE,
// inserts bubbles on load-use stall or flush, and holds while EXE is busy (multi-cycle mul/div).
// Drives id_stall back to PC/IF-ID. Saturating bubble counter for performance debug.
// PARAMETERS
// DATA_W   32  operand / PC width
// IDX_W    5   register index width
// CTRL_W   16  opaque decoded-control bundle width (ALU op, mem op, imm-select, ...)
// CNT_W    16  bubble counter width
// PORTS
// clk_sig        in  1       clock; all state on posedge
// rst_sig        in  1       synchronous, active-high reset
// id_valid       in  1       ID holds a real instruction
// id_pc          in  DATA_W  ID PC
// id_opcode      in  6       ID opcode
// id_func_code   in  6       ID function field
// id_rs_data     in  DATA_W  regfile rs read value
// id_rt_data     in  DATA_W  regfile rt read value
// id_hi_data     in  DATA_W  HI register value
// id_lo_data     in  DATA_W  LO register value
// id_imm         in  DATA_W  extended immediate
// id_rd_idx      in  IDX_W   destination index
// id_rd_wena     in  1       GPR write enable
// id_hi_wena     in  1       HI write enable
// id_lo_wena     in  1       LO write enable
// id_ctrl        in  CTRL_W  decoded control bundle
// fwd_stall      in  1       load-use stall from data_forward (stable across posedge)
// fwd_forward    in  1       a forwarded value is valid
// fwd_is_rs      in  1       forwarded rs valid
// fwd_is_rt      in  1       forwarded rt valid
// fwd_rs_data    in  DATA_W  forwarded rs
// fwd_rt_data    in  DATA_W  forwarded rt
// fwd_hi_data    in  DATA_W  forwarded HI
// fwd_lo_data    in  DATA_W  forwarded LO
// flush          in  1       branch/jump redirect: kill ID instruction
// exe_busy       in  1       EXE multi-cycle unit busy; freeze EXE register
// exe_valid, exe_pc, exe_opcode, exe_func_code, exe_rs_val, exe_rt_val, exe_hi_val, exe_lo_val,
// exe_imm, exe_rd_idx, exe_rd_wena, exe_hi_wena, exe_lo_wena, exe_ctrl
//                out (widths as id_*)  registered EXE copy
// id_stall       out 1       combinational: hold PC and IF/ID this cycle
// bubble_cnt     out CNT_W   bubbles inserted since reset, saturating
// BEHAVIOUR
// - Reset: state=S_RUN; all exe_* = 0 (opcode/func 0 = NOP); bubble_cnt=0. id_stall=0 in reset.
// - Operand select: rs = (fwd_forward&fwd_is_rs)?fwd_rs_data:id_rs_data; rt likewise.
//   hi = (fwd_forward & MFHI)?fwd_hi_data:id_hi_data; lo likewise for MFLO (`OPC_/`FNC_ codes).
// - Bubble = exe_valid=0, all wena=0, ctrl=0, opcode=func=0; data fields don't-care (drive 0).
// - Priority each edge: rst_sig > flush > exe_busy > fwd_stall > capture.
// - S_RUN: flush -> bubble, stay. exe_busy -> hold EXE, id_stall=1, ->S_HOLD.
//   fwd_stall -> bubble, id_stall=1, ->S_LDUSE. else capture ID, 1-cycle latency.
// - S_LDUSE: fwd_* now carry load result; capture ID using select rule, id_stall=0, ->S_RUN.
//   fwd_stall ignored here (forwarder self-clears). flush -> bubble, ->S_RUN.
// - S_HOLD: exe_* frozen, id_stall=1 while exe_busy. exe_busy=0 -> capture (apply select,
//   fwd_stall may re-trigger S_LDUSE as in S_RUN). flush -> bubble, ->S_RUN.
// - bubble_cnt +1 on every bubble-inserting edge; holds at all-ones. Holds do not count.
// - id_valid=0 captures as bubble but not counted.
// STRUCTURE
// - State encodings (S_RUN/S_LDUSE/S_HOLD), NOP bundle constant in mips_def.vh.
// - One sub-module natural: id_exe_operand_sel (combinational rs/rt/hi/lo mux).
// TESTING
// 1 reset mid-HOLD: rst_sig=1 one edge -> exe_valid=0, bubble_cnt=0, state S_RUN, id_stall=0.
// 2 ADD, fwd_is_rs=1 fwd_rs_data=0x11, id_rs_data=0x22 -> next edge exe_rs_val=0x11, valid=1.
// 3 LW then dependent ADD: fwd_stall=1 -> bubble, id_stall=1, bubble_cnt=1; next edge
//   fwd_rs_data=0xCAFE -> exe_rs_val=0xCAFE, id_stall=0.
// 4 MFHI with fwd_forward=1 fwd_hi_data=0x5 id_hi_data=0x9 -> exe_hi_val=0x5.
// 5 exe_busy 3 cycles with fwd_stall=1 -> exe_* frozen, id_stall=1, bubble_cnt unchanged.
// 6 flush with exe_busy=1 -> bubble wins; counter saturation: preload all-ones, bubble -> stays.

Source files
------------

// File: rtl/id_exe_pipe_reg_pkg.sv
// Shared definitions for the ID->EXE pipeline register: FSM states, NOP codes and
// helpers that recognise the HI/LO move instructions.
package id_exe_pipe_reg_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StLduse = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_NOP     = 6'h00;
  localparam logic [5:0] FNC_NOP     = 6'h00;
  localparam logic [5:0] FNC_MFHI    = 6'h10;
  localparam logic [5:0] FNC_MFLO    = 6'h12;

  function automatic logic is_mfhi(logic [5:0] opcode, logic [5:0] func_code);
    return (opcode == OPC_SPECIAL) && (func_code == FNC_MFHI);
  endfunction

  function automatic logic is_mflo(logic [5:0] opcode, logic [5:0] func_code);
    return (opcode == OPC_SPECIAL) && (func_code == FNC_MFLO);
  endfunction

endpackage

// File: rtl/id_exe_pipe_reg_if.sv
// Bundle of ID-stage inputs, forwarding/hazard controls and registered EXE outputs.
interface id_exe_pipe_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [5:0]        id_opcode;
  logic [5:0]        id_func_code;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_hi_data;
  logic [DATA_W-1:0] id_lo_data;
  logic [DATA_W-1:0] id_imm;
  logic [IDX_W-1:0]  id_rd_idx;
  logic              id_rd_wena;
  logic              id_hi_wena;
  logic              id_lo_wena;
  logic [CTRL_W-1:0] id_ctrl;

  logic              fwd_stall;
  logic              fwd_forward;
  logic              fwd_is_rs;
  logic              fwd_is_rt;
  logic [DATA_W-1:0] fwd_rs_data;
  logic [DATA_W-1:0] fwd_rt_data;
  logic [DATA_W-1:0] fwd_hi_data;
  logic [DATA_W-1:0] fwd_lo_data;
  logic              flush;
  logic              exe_busy;

  logic              exe_valid;
  logic [DATA_W-1:0] exe_pc;
  logic [5:0]        exe_opcode;
  logic [5:0]        exe_func_code;
  logic [DATA_W-1:0] exe_rs_val;
  logic [DATA_W-1:0] exe_rt_val;
  logic [DATA_W-1:0] exe_hi_val;
  logic [DATA_W-1:0] exe_lo_val;
  logic [DATA_W-1:0] exe_imm;
  logic [IDX_W-1:0]  exe_rd_idx;
  logic              exe_rd_wena;
  logic              exe_hi_wena;
  logic              exe_lo_wena;
  logic [CTRL_W-1:0] exe_ctrl;
  logic              id_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_pc, id_opcode, id_func_code, id_rs_data, id_rt_data, id_hi_data,
           id_lo_data, id_imm, id_rd_idx, id_rd_wena, id_hi_wena, id_lo_wena, id_ctrl,
           fwd_stall, fwd_forward, fwd_is_rs, fwd_is_rt, fwd_rs_data, fwd_rt_data,
           fwd_hi_data, fwd_lo_data, flush, exe_busy,
    input  exe_valid, exe_pc, exe_opcode, exe_func_code, exe_rs_val, exe_rt_val, exe_hi_val,
           exe_lo_val, exe_imm, exe_rd_idx, exe_rd_wena, exe_hi_wena, exe_lo_wena, exe_ctrl,
           id_stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_opcode, id_func_code, id_rs_data, id_rt_data, id_hi_data,
           id_lo_data, id_imm, id_rd_idx, id_rd_wena, id_hi_wena, id_lo_wena, id_ctrl,
           fwd_stall, fwd_forward, fwd_is_rs, fwd_is_rt, fwd_rs_data, fwd_rt_data,
           fwd_hi_data, fwd_lo_data, flush, exe_busy,
    output exe_valid, exe_pc, exe_opcode, exe_func_code, exe_rs_val, exe_rt_val, exe_hi_val,
           exe_lo_val, exe_imm, exe_rd_idx, exe_rd_wena, exe_hi_wena, exe_lo_wena, exe_ctrl,
           id_stall, bubble_cnt
  );
endinterface

// File: rtl/id_exe_operand_sel.sv
// Chooses forwarded versus register-file values for rs/rt and, for MFHI/MFLO, HI/LO.
module id_exe_operand_sel
  import id_exe_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        func_code,
  input  logic              fwd_forward,
  input  logic              fwd_is_rs,
  input  logic              fwd_is_rt,
  input  logic [DATA_W-1:0] fwd_rs_data,
  input  logic [DATA_W-1:0] fwd_rt_data,
  input  logic [DATA_W-1:0] fwd_hi_data,
  input  logic [DATA_W-1:0] fwd_lo_data,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_hi_data,
  input  logic [DATA_W-1:0] id_lo_data,
  output logic [DATA_W-1:0] rs_sel,
  output logic [DATA_W-1:0] rt_sel,
  output logic [DATA_W-1:0] hi_sel,
  output logic [DATA_W-1:0] lo_sel
);
  always_comb begin
    rs_sel = (fwd_forward && fwd_is_rs) ? fwd_rs_data : id_rs_data;
    rt_sel = (fwd_forward && fwd_is_rt) ? fwd_rt_data : id_rt_data;
    hi_sel = (fwd_forward && is_mfhi(opcode, func_code)) ? fwd_hi_data : id_hi_data;
    lo_sel = (fwd_forward && is_mflo(opcode, func_code)) ? fwd_lo_data : id_lo_data;
  end
endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register: captures operands and control, inserts bubbles on load-use
// stall or flush, freezes while EXE is busy, and counts inserted bubbles (saturating).
module id_exe_pipe_reg
  import id_exe_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input logic clk_sig,
  input logic rst_sig,
  id_exe_pipe_reg_if.slave bus
);
  state_e state_q, state_d;
  logic   hold, bubble, count_bubble, stall, kill;
  logic [DATA_W-1:0] rs_sel, rt_sel, hi_sel, lo_sel;

  logic              exe_valid_q, exe_rd_wena_q, exe_hi_wena_q, exe_lo_wena_q;
  logic [DATA_W-1:0] exe_pc_q, exe_rs_q, exe_rt_q, exe_hi_q, exe_lo_q, exe_imm_q;
  logic [5:0]        exe_opcode_q, exe_func_q;
  logic [IDX_W-1:0]  exe_rd_idx_q;
  logic [CTRL_W-1:0] exe_ctrl_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  id_exe_operand_sel #(.DATA_W(DATA_W)) u_operand_sel (
    .opcode      (bus.id_opcode),
    .func_code   (bus.id_func_code),
    .fwd_forward (bus.fwd_forward),
    .fwd_is_rs   (bus.fwd_is_rs),
    .fwd_is_rt   (bus.fwd_is_rt),
    .fwd_rs_data (bus.fwd_rs_data),
    .fwd_rt_data (bus.fwd_rt_data),
    .fwd_hi_data (bus.fwd_hi_data),
    .fwd_lo_data (bus.fwd_lo_data),
    .id_rs_data  (bus.id_rs_data),
    .id_rt_data  (bus.id_rt_data),
    .id_hi_data  (bus.id_hi_data),
    .id_lo_data  (bus.id_lo_data),
    .rs_sel      (rs_sel),
    .rt_sel      (rt_sel),
    .hi_sel      (hi_sel),
    .lo_sel      (lo_sel)
  );

  always_comb begin
    state_d      = state_q;
    hold         = 1'b0;
    bubble       = 1'b0;
    count_bubble = 1'b0;
    stall        = 1'b0;
    unique case (state_q)
      StRun, StHold: begin
        if (bus.flush) begin
          bubble = 1'b1; count_bubble = 1'b1; state_d = StRun;
        end else if (bus.exe_busy) begin
          hold = 1'b1; stall = 1'b1; state_d = StHold;
        end else if (bus.fwd_stall) begin
          bubble = 1'b1; count_bubble = 1'b1; stall = 1'b1; state_d = StLduse;
        end else begin
          state_d = StRun;
        end
      end
      StLduse: begin
        // Forwarder clears its own stall; the load result is on fwd_* now
        if (bus.flush) begin
          bubble = 1'b1; count_bubble = 1'b1; state_d = StRun;
        end else if (bus.exe_busy) begin
          hold = 1'b1; stall = 1'b1; state_d = StHold;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign kill = bubble | ~bus.id_valid;

  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      state_q       <= StRun;
      exe_valid_q   <= 1'b0;
      exe_pc_q      <= '0;
      exe_opcode_q  <= OPC_NOP;
      exe_func_q    <= FNC_NOP;
      exe_rs_q      <= '0;
      exe_rt_q      <= '0;
      exe_hi_q      <= '0;
      exe_lo_q      <= '0;
      exe_imm_q     <= '0;
      exe_rd_idx_q  <= '0;
      exe_rd_wena_q <= 1'b0;
      exe_hi_wena_q <= 1'b0;
      exe_lo_wena_q <= 1'b0;
      exe_ctrl_q    <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (count_bubble && !(&bubble_cnt_q)) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      if (!hold) begin
        exe_valid_q   <= ~kill;
        exe_pc_q      <= kill ? '0 : bus.id_pc;
        exe_opcode_q  <= kill ? OPC_NOP : bus.id_opcode;
        exe_func_q    <= kill ? FNC_NOP : bus.id_func_code;
        exe_rs_q      <= kill ? '0 : rs_sel;
        exe_rt_q      <= kill ? '0 : rt_sel;
        exe_hi_q      <= kill ? '0 : hi_sel;
        exe_lo_q      <= kill ? '0 : lo_sel;
        exe_imm_q     <= kill ? '0 : bus.id_imm;
        exe_rd_idx_q  <= kill ? '0 : bus.id_rd_idx;
        exe_rd_wena_q <= ~kill & bus.id_rd_wena;
        exe_hi_wena_q <= ~kill & bus.id_hi_wena;
        exe_lo_wena_q <= ~kill & bus.id_lo_wena;
        exe_ctrl_q    <= kill ? '0 : bus.id_ctrl;
      end
    end
  end

  assign bus.exe_valid     = exe_valid_q;
  assign bus.exe_pc        = exe_pc_q;
  assign bus.exe_opcode    = exe_opcode_q;
  assign bus.exe_func_code = exe_func_q;
  assign bus.exe_rs_val    = exe_rs_q;
  assign bus.exe_rt_val    = exe_rt_q;
  assign bus.exe_hi_val    = exe_hi_q;
  assign bus.exe_lo_val    = exe_lo_q;
  assign bus.exe_imm       = exe_imm_q;
  assign bus.exe_rd_idx    = exe_rd_idx_q;
  assign bus.exe_rd_wena   = exe_rd_wena_q;
  assign bus.exe_hi_wena   = exe_hi_wena_q;
  assign bus.exe_lo_wena   = exe_lo_wena_q;
  assign bus.exe_ctrl      = exe_ctrl_q;
  assign bus.bubble_cnt    = bubble_cnt_q;
  assign bus.id_stall      = stall & ~rst_sig;
endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed plus random stimulus against a behavioural model of the ID->EXE register.
module tb_id_exe_pipe_reg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk_sig = 1'b0;
  logic rst_sig;
  always #5 clk_sig = ~clk_sig;

  id_exe_pipe_reg_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_exe_pipe_reg #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_sig (clk_sig),
    .rst_sig (rst_sig),
    .bus     (bus)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  opc;
    logic [5:0]  fnc;
    logic [31:0] rs, rt, hi, lo, imm;
    logic [4:0]  rd;
    logic        rdw, hiw, low;
    logic [15:0] ctrl;
  } exe_t;

  exe_t        m;
  int unsigned m_cnt;
  bit          m_after_lduse;
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_stall();
    if (rst_sig || bus.flush) return 1'b0;
    if (bus.exe_busy) return 1'b1;
    return bus.fwd_stall && !m_after_lduse;
  endfunction

  task automatic model_edge();
    exe_t z = '{default: '0};
    exe_t c;
    if (rst_sig) begin
      m = z; m_cnt = 0; m_after_lduse = 0;
    end else if (bus.flush) begin
      m = z; if (m_cnt < CNT_MAX) m_cnt++; m_after_lduse = 0;
    end else if (bus.exe_busy) begin
      m_after_lduse = 0;
    end else if (bus.fwd_stall && !m_after_lduse) begin
      m = z; if (m_cnt < CNT_MAX) m_cnt++; m_after_lduse = 1;
    end else begin
      c.valid = 1'b1;
      c.pc    = bus.id_pc;
      c.opc   = bus.id_opcode;
      c.fnc   = bus.id_func_code;
      c.rs    = (bus.fwd_forward && bus.fwd_is_rs) ? bus.fwd_rs_data : bus.id_rs_data;
      c.rt    = (bus.fwd_forward && bus.fwd_is_rt) ? bus.fwd_rt_data : bus.id_rt_data;
      c.hi    = (bus.fwd_forward && bus.id_opcode == 6'h00 && bus.id_func_code == 6'h10)
                ? bus.fwd_hi_data : bus.id_hi_data;
      c.lo    = (bus.fwd_forward && bus.id_opcode == 6'h00 && bus.id_func_code == 6'h12)
                ? bus.fwd_lo_data : bus.id_lo_data;
      c.imm   = bus.id_imm;
      c.rd    = bus.id_rd_idx;
      c.rdw   = bus.id_rd_wena;
      c.hiw   = bus.id_hi_wena;
      c.low   = bus.id_lo_wena;
      c.ctrl  = bus.id_ctrl;
      m = bus.id_valid ? c : z;
      m_after_lduse = 0;
    end
  endtask

  task automatic compare_all();
    check("exe_valid", bus.exe_valid, m.valid);
    check("exe_pc", bus.exe_pc, m.pc);
    check("exe_opcode", bus.exe_opcode, m.opc);
    check("exe_func_code", bus.exe_func_code, m.fnc);
    check("exe_rs_val", bus.exe_rs_val, m.rs);
    check("exe_rt_val", bus.exe_rt_val, m.rt);
    check("exe_hi_val", bus.exe_hi_val, m.hi);
    check("exe_lo_val", bus.exe_lo_val, m.lo);
    check("exe_imm", bus.exe_imm, m.imm);
    check("exe_rd_idx", bus.exe_rd_idx, m.rd);
    check("exe_wena", {bus.exe_rd_wena, bus.exe_hi_wena, bus.exe_lo_wena},
          {m.rdw, m.hiw, m.low});
    check("exe_ctrl", bus.exe_ctrl, m.ctrl);
    check("bubble_cnt", bus.bubble_cnt, m_cnt);
  endtask

  task automatic tick();
    #1;
    check("id_stall", bus.id_stall, exp_stall());
    @(posedge clk_sig);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_id();
    bus.id_valid     = 1'b1;
    bus.id_pc        = $urandom;
    bus.id_opcode    = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
    case ($urandom_range(0, 2))
      0:       bus.id_func_code = 6'h10;
      1:       bus.id_func_code = 6'h12;
      default: bus.id_func_code = 6'($urandom);
    endcase
    bus.id_rs_data   = $urandom;
    bus.id_rt_data   = $urandom;
    bus.id_hi_data   = $urandom;
    bus.id_lo_data   = $urandom;
    bus.id_imm       = $urandom;
    bus.id_rd_idx    = 5'($urandom);
    bus.id_rd_wena   = 1'($urandom);
    bus.id_hi_wena   = 1'($urandom);
    bus.id_lo_wena   = 1'($urandom);
    bus.id_ctrl      = 16'($urandom);
    bus.fwd_rs_data  = $urandom;
    bus.fwd_rt_data  = $urandom;
    bus.fwd_hi_data  = $urandom;
    bus.fwd_lo_data  = $urandom;
    bus.fwd_forward  = 1'b0;
    bus.fwd_is_rs    = 1'b0;
    bus.fwd_is_rt    = 1'b0;
  endtask

  initial begin
    m = '{default: '0};
    m_cnt = 0;
    m_after_lduse = 0;
    rand_id();
    bus.fwd_stall = 1'b0;
    bus.flush     = 1'b0;
    bus.exe_busy  = 1'b0;
    rst_sig       = 1'b1;
    tick();
    rst_sig = 1'b0;

    // Enter HOLD, then reset in the middle of it
    tick();
    bus.exe_busy = 1'b1;
    tick();
    tick();
    rst_sig = 1'b1;
    tick();
    check("t1_valid", bus.exe_valid, 1'b0);
    check("t1_cnt", bus.bubble_cnt, 0);
    rst_sig = 1'b0;
    bus.exe_busy = 1'b0;

    // ADD with forwarded rs
    rand_id();
    bus.id_opcode = 6'h00; bus.id_func_code = 6'h20;
    bus.fwd_forward = 1'b1; bus.fwd_is_rs = 1'b1;
    bus.fwd_rs_data = 32'h11; bus.id_rs_data = 32'h22;
    tick();
    check("t2_rs", bus.exe_rs_val, 32'h11);
    check("t2_valid", bus.exe_valid, 1'b1);

    // Load-use: bubble, then capture with the load result forwarded
    rand_id();
    bus.id_opcode = 6'h00; bus.id_func_code = 6'h20;
    bus.fwd_stall = 1'b1;
    tick();
    check("t3_cnt", bus.bubble_cnt, 1);
    bus.fwd_forward = 1'b1; bus.fwd_is_rs = 1'b1; bus.fwd_rs_data = 32'hCAFE;
    tick();
    check("t3_rs", bus.exe_rs_val, 32'hCAFE);
    bus.fwd_stall = 1'b0;

    // MFHI with forwarded HI
    rand_id();
    bus.id_opcode = 6'h00; bus.id_func_code = 6'h10;
    bus.fwd_forward = 1'b1; bus.fwd_hi_data = 32'h5; bus.id_hi_data = 32'h9;
    tick();
    check("t4_hi", bus.exe_hi_val, 32'h5);

    // Busy for three cycles while a load-use stall is pending
    rand_id();
    bus.exe_busy = 1'b1; bus.fwd_stall = 1'b1;
    repeat (3) tick();
    bus.exe_busy = 1'b0;
    tick();
    bus.fwd_stall = 1'b0;
    tick();

    // Flush beats busy; then saturate the counter
    bus.flush = 1'b1; bus.exe_busy = 1'b1;
    tick();
    bus.exe_busy = 1'b0;
    repeat (CNT_MAX + 3) tick();
    check("t6_sat", bus.bubble_cnt, CNT_MAX);
    bus.flush = 1'b0;

    rst_sig = 1'b1;
    tick();
    rst_sig = 1'b0;

    for (int i = 0; i < 400; i++) begin
      rand_id();
      bus.id_valid    = ($urandom_range(0, 7) != 0);
      bus.fwd_forward = 1'($urandom);
      bus.fwd_is_rs   = 1'($urandom);
      bus.fwd_is_rt   = 1'($urandom);
      bus.fwd_stall   = ($urandom_range(0, 4) == 0);
      bus.exe_busy    = ($urandom_range(0, 3) == 0);
      bus.flush       = ($urandom_range(0, 15) == 0);
      rst_sig         = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
